// File: rtl/alu_arbiter.sv
// Two-requester front end that time-shares one 4-bit ALU. It accepts one command,
// runs it through EXEC, and holds the result in RESP until the consumer takes it.
//
// Handshake: a transfer happens on any rising edge where valid & ready are both high.
//   - reqN_ready is combinational and can be high only in IDLE, outside reset,
//     and only for the granted requester.
//   - rsp_valid stays high, with stable rsp_data/rsp_id/rsp_op, until a cycle
//     where rsp_ready is also high.

module alu_top (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [3:0] alu_out
);
  always_comb begin
    alu_out = 4'd0;
    unique case (op)
      2'b00: alu_out = a + b;
      2'b01: alu_out = a - b;
      2'b10: alu_out = a & b;
      2'b11: alu_out = a | b;
      default: alu_out = 4'd0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_id,
  output logic [1:0] rsp_op,
  output logic       busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic       grant_id;
  logic       accept;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] op_q;
  logic       id_q;
  logic [3:0] alu_out;

  // grant_id is only meaningful when the matching valid is high; ready is gated below.
  always_comb begin
    grant_id = ~req0_valid;
    if (!FIXED_PRIO && req0_valid && req1_valid) grant_id = ~last_grant;
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE && !rst) begin
      req0_ready = req0_valid & ~grant_id;
      req1_ready = req1_valid &  grant_id;
    end
  end

  assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      op_q       <= 2'd0;
      id_q       <= 1'b0;
    end else if (accept) begin
      last_grant <= grant_id;
      id_q       <= grant_id;
      a_q        <= grant_id ? req1_a  : req0_a;
      b_q        <= grant_id ? req1_b  : req0_b;
      op_q       <= grant_id ? req1_op : req0_op;
    end
  end

  alu_top u_alu (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .alu_out (alu_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= 4'd0;
      rsp_id   <= 1'b0;
      rsp_op   <= 2'd0;
    end else if (state == EXEC) begin
      rsp_data <= alu_out;
      rsp_id   <= id_q;
      rsp_op   <= op_q;
    end
  end

  assign rsp_valid = (state == RESP) && !rst;
  assign busy      = (state != IDLE) && !rst;
endmodule
